// File: rtl/mem_pkg.sv
// Shared definitions for the processor-side memory burst controller:
// bus widths, FSM state encoding, request record and the range helper.
package mem_pkg;

    localparam int AW        = 5;
    localparam int DW        = 16;
    localparam int MAX_BURST = 4;
    localparam int CW        = $clog2(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        LOAD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic          write;
        logic [AW-1:0] base;
        logic [CW-1:0] len;
    } mem_req_t;

    // High when the last word of a burst would fall past the top word address.
    function automatic logic range_ovf(input logic [AW-1:0] base, input logic [CW-1:0] len);
        logic [AW:0] sum;
        sum = {1'b0, base} + (AW+1)'(len);
        return sum[AW];
    endfunction

endpackage

// File: rtl/mem_addr_gen.sv
// Burst address generator: holds the latched base/length and the running
// word index, and presents base+idx (modulo 2^AW) to the Memory port.
// Also flags incoming requests whose burst would run past the top address.
module mem_addr_gen
    import mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] req_base,
    input  logic [CW-1:0] req_len,
    input  logic          inc,
    output logic [AW-1:0] adr,
    output logic          last,
    output logic          ovf
);

    logic [AW-1:0] base;
    logic [CW-1:0] len;
    logic [CW-1:0] idx;

    // Latch a new burst on accept, otherwise step the index per word moved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base <= '0;
            len  <= '0;
            idx  <= '0;
        end else if (load) begin
            base <= req_base;
            len  <= req_len;
            idx  <= '0;
        end else if (inc) begin
            idx  <= idx + 1'b1;
        end
    end

    assign adr  = base + {{(AW-CW){1'b0}}, idx};
    assign last = (idx == len);
    assign ovf  = range_ovf(req_base, req_len);

endmodule

// File: rtl/mem_burst_ctrl.sv
// Processor-side initiator for the single-port data Memory. Accepts single
// or burst load/store requests, walks consecutive addresses on the Memory
// port and returns load words over a registered valid/ready stream.
// Optional build macro MEM_RANGE_CHK_EN: requests running past the top
// address are accepted but dropped with a one-cycle err pulse; without it
// addresses wrap modulo 2^AW and err stays 0.
module mem_burst_ctrl
    import mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_base,
    input  logic [CW-1:0] req_len,
    input  logic          st_valid,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    output logic          ld_valid,
    output logic [DW-1:0] ld_data,
    output logic          ld_last,
    input  logic          ld_ready,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd,
    output logic          err
);

    state_t   state;
    mem_req_t req;
    logic     accept;
    logic     start;
    logic     capture;
    logic     inc;
    logic     last;
    logic     ovf;

    assign req       = {req_write, req_base, req_len};
    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

`ifdef MEM_RANGE_CHK_EN
    assign start = accept && !ovf;
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
    assign start      = accept;
`endif

    // A load word is taken from Memory whenever the output slot is free or draining.
    assign capture  = (state == LOAD) && (!ld_valid || ld_ready);
    assign inc      = ((state == STORE) && st_valid) || capture;

    // Store data flows straight through; Memory writes on the same rising edge.
    assign st_ready = (state == STORE);
    assign mem_we   = (state == STORE) && st_valid;
    assign mem_wd   = (state == STORE) ? st_data : '0;

    mem_addr_gen u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start),
        .req_base (req.base),
        .req_len  (req.len),
        .inc      (inc),
        .adr      (mem_adr),
        .last     (last),
        .ovf      (ovf)
    );

    // Control FSM plus the registered load-return stage and err pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ld_valid <= 1'b0;
            ld_data  <= '0;
            ld_last  <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef MEM_RANGE_CHK_EN
                        if (ovf) begin
                            err <= 1'b1;
                        end else begin
                            state <= req.write ? STORE : LOAD;
                        end
`else
                        state <= req.write ? STORE : LOAD;
`endif
                    end
                end
                STORE: begin
                    if (st_valid && last) begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    if (capture) begin
                        ld_data  <= mem_rd;
                        ld_valid <= 1'b1;
                        ld_last  <= last;
                        if (last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (ld_ready) begin
                        ld_valid <= 1'b0;
                        ld_last  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl with a behavioural Memory model,
// a write scoreboard and a load-return scoreboard.
module tb_mem_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [4:0]  req_base;
    logic [1:0]  req_len;
    logic        st_valid;
    logic [15:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic [4:0]  mem_adr;
    logic [15:0] mem_wd;
    logic        mem_we;
    logic [15:0] mem_rd;
    logic        err;

    always #5 clk = ~clk;

    mem_burst_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_base  (req_base),
        .req_len   (req_len),
        .st_valid  (st_valid),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .mem_adr   (mem_adr),
        .mem_wd    (mem_wd),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .err       (err)
    );

    // Memory model: synchronous write, combinational read.
    logic [15:0] mem [0:31];
    always @(posedge clk) if (mem_we) mem[mem_adr] <= mem_wd;
    assign mem_rd = mem[mem_adr];

    typedef struct packed { logic [4:0] adr; logic [15:0] d; } wexp_t;
    typedef struct packed { logic [15:0] d; logic last; } lexp_t;

    typedef struct {
        logic             wr;
        logic [4:0]       base;
        logic [1:0]       len;
        logic [3:0][15:0] d;
        logic [3:0][4:0]  adr;
        logic [7:0]       pat;
        int               stall_at;
        int               stall_n;
    } vec_t;

    wexp_t wq[$];
    lexp_t lq[$];
    int    checks = 0;
    int    errors = 0;
    int    delivered = 0;
    int    err_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 32'(mem_adr), 32'h3f);
                end else begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("wr_adr", 32'(mem_adr), 32'(e.adr));
                    chk("wr_data", 32'(mem_wd), 32'(e.d));
                end
            end
            if (ld_valid) begin
                if (lq.size() == 0) begin
                    chk("unexpected_ld", 32'(ld_data), 32'h1ffff);
                end else begin
                    chk("ld_data", 32'(ld_data), 32'(lq[0].d));
                    chk("ld_last", 32'(ld_last), 32'(lq[0].last));
                    if (ld_ready) begin
                        void'(lq.pop_front());
                        delivered++;
                    end
                end
            end
            if (err) err_seen++;
        end
    end

    function automatic vec_t mk(input logic wr, input logic [4:0] b, input logic [1:0] l,
                                input logic [15:0] d0, input logic [15:0] d1,
                                input logic [15:0] d2, input logic [15:0] d3,
                                input logic [7:0] pat, input int sa, input int sn);
        vec_t v;
        v.wr = wr; v.base = b; v.len = l;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        for (int i = 0; i < 4; i++) v.adr[i] = 5'(b + 5'(i));
        v.pat = pat; v.stall_at = sa; v.stall_n = sn;
        return v;
    endfunction

    task automatic do_req(input logic wr, input logic [4:0] b, input logic [1:0] l);
        req_valid = 1'b1; req_write = wr; req_base = b; req_len = l;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic store_run(input vec_t v);
        int n, w, c;
        n = int'(v.len) + 1;
        for (int i = 0; i < n; i++) wq.push_back({v.adr[i], v.d[i]});
        do_req(1'b1, v.base, v.len);
        chk("st_ready_store", 32'(st_ready), 32'd1);
        w = 0; c = 0;
        while (w < n && c < 40) begin
            st_valid = v.pat[c % 8];
            st_data  = v.d[w];
            @(posedge clk); #1;
            if (st_valid) w++;
            c++;
        end
        st_valid = 1'b0;
        chk("store_done", 32'(w), 32'(n));
        chk("store_idle", 32'(req_ready), 32'd1);
        chk("store_all_written", 32'(wq.size()), 32'd0);
    endtask

    task automatic load_run(input vec_t v);
        int n, cyc, stalled, base_cnt;
        n = int'(v.len) + 1;
        for (int i = 0; i < n; i++) lq.push_back({v.d[i], (i == n - 1)});
        base_cnt = delivered;
        ld_ready = 1'b1;
        do_req(1'b0, v.base, v.len);
        chk("ld_latency0", 32'(ld_valid), 32'd0);
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("ld_latency1", 32'(ld_valid), 32'd1);
        cyc = 0; stalled = 0;
        while (lq.size() > 0 && cyc < 50) begin
            if (ld_valid && (delivered - base_cnt) == v.stall_at && stalled < v.stall_n) begin
                ld_ready = 1'b0;
                stalled++;
                chk("req_ready_stall", 32'(req_ready), 32'd0);
            end else begin
                ld_ready = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        ld_ready = 1'b1;
        chk("load_complete", 32'(lq.size()), 32'd0);
        chk("load_cycles", 32'(cyc), 32'(n + v.stall_n));
        chk("load_idle", 32'(req_ready), 32'd1);
        chk("load_ld_valid_low", 32'(ld_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vec_t v;

        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
        vecs[0] = mk(1'b1, 5'd0,  2'd0, 16'hA5A5, 16'h0,    16'h0,    16'h0,    8'hFF,     -1, 0);
        vecs[1] = mk(1'b0, 5'd0,  2'd0, 16'hA5A5, 16'h0,    16'h0,    16'h0,    8'hFF,     -1, 0);
        vecs[2] = mk(1'b1, 5'd4,  2'd3, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 8'hFF,     -1, 0);
        vecs[3] = mk(1'b0, 5'd4,  2'd3, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 8'hFF,     -1, 0);
        vecs[4] = mk(1'b0, 5'd4,  2'd3, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 8'hFF,      2, 3);
        vecs[5] = mk(1'b1, 5'd16, 2'd2, 16'h5A01, 16'h5A02, 16'h5A03, 16'h0,    8'b0001_0101, -1, 0);
        vecs[6] = mk(1'b0, 5'd16, 2'd2, 16'h5A01, 16'h5A02, 16'h5A03, 16'h0,    8'hFF,     -1, 0);

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_base = '0; req_len = '0;
        st_valid = 1'b0; st_data = '0; ld_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_ld_valid", 32'(ld_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_ld_data", 32'(ld_data), 32'd0);
        chk("rst_ld_last", 32'(ld_last), 32'd0);
        chk("rst_mem_adr", 32'(mem_adr), 32'd0);
        chk("rst_mem_wd", 32'(mem_wd), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_st_ready", 32'(st_ready), 32'd0);

        for (int k = 0; k < 7; k++) begin
            if (vecs[k].wr) store_run(vecs[k]);
            else load_run(vecs[k]);
            @(posedge clk); #1;
        end

        // Store data offered while idle must be ignored.
        st_valid = 1'b1; st_data = 16'hDEAD;
        for (int k = 0; k < 2; k++) begin
            chk("idle_st_ready", 32'(st_ready), 32'd0);
            chk("idle_mem_we", 32'(mem_we), 32'd0);
            @(posedge clk); #1;
        end
        st_valid = 1'b0;

`ifdef MEM_RANGE_CHK_EN
        do_req(1'b1, 5'd30, 2'd3);
        chk("range_err_pulse", 32'(err), 32'd1);
        chk("range_idle", 32'(req_ready), 32'd1);
        chk("range_st_ready", 32'(st_ready), 32'd0);
        st_valid = 1'b1; st_data = 16'hFFFF;
        chk("range_no_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        chk("range_err_clear", 32'(err), 32'd0);
        chk("range_no_ld", 32'(ld_valid), 32'd0);
        st_valid = 1'b0;
        chk("range_err_count", 32'(err_seen), 32'd1);
`else
        v = mk(1'b1, 5'd30, 2'd3, 16'hC001, 16'hC002, 16'hC003, 16'hC004, 8'hFF, -1, 0);
        v.adr[0] = 5'd30; v.adr[1] = 5'd31; v.adr[2] = 5'd0; v.adr[3] = 5'd1;
        store_run(v);
        v.wr = 1'b0;
        load_run(v);
        chk("err_never", 32'(err_seen), 32'd0);
`endif
        @(posedge clk); #1;

        // Reset in the middle of a four-word store.
        wq.push_back({5'd8, 16'hBEE0});
        wq.push_back({5'd9, 16'hBEE1});
        do_req(1'b1, 5'd8, 2'd3);
        for (int k = 0; k < 2; k++) begin
            st_valid = 1'b1; st_data = (k == 0) ? 16'hBEE0 : 16'hBEE1;
            @(posedge clk); #1;
        end
        st_valid = 1'b1; st_data = 16'hBEE2;
        chk("midrst_we_before", 32'(mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_we_drop", 32'(mem_we), 32'd0);
        st_valid = 1'b0;
        chk("midrst_two_written", 32'(wq.size()), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_ld_valid", 32'(ld_valid), 32'd0);
        chk("midrst_mem_adr", 32'(mem_adr), 32'd0);
        v = mk(1'b0, 5'd8, 2'd3, 16'hBEE0, 16'hBEE1, 16'h0000, 16'h0000, 8'hFF, -1, 0);
        load_run(v);

        @(posedge clk); #1;
        chk("final_wq_empty", 32'(wq.size()), 32'd0);
        chk("final_lq_empty", 32'(lq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
